// File: rtl/mul_pipe_sched.sv
// ============================================================================
// mul_pipe_sched: round-robin scheduler and stage controller for one shared
// pipelined FP multiplier. It tracks valid/id/tag for each stage and returns them with each result.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mul_pipe_sched #(
  parameter  int SIGN_W     = 1,
  parameter  int EXPO_W     = 8,
  parameter  int MANT_W     = 23,
  parameter  int NUM_REQ    = 2,
  parameter  int PIPE_DEPTH = 3,
  parameter  int TAG_W      = 4,
  localparam int OP_W       = SIGN_W + EXPO_W + MANT_W,
  localparam int IDX_W      = $clog2(NUM_REQ),
  localparam int OCC_W      = $clog2(PIPE_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*OP_W-1:0]  req_a,
  input  logic [NUM_REQ*OP_W-1:0]  req_b,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic [OP_W-1:0]          pipe_a,
  output logic [OP_W-1:0]          pipe_b,
  output logic [PIPE_DEPTH-1:0]    pipe_en,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDX_W-1:0]         rsp_id,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic [OCC_W-1:0]         occupancy
);

  logic [PIPE_DEPTH-1:0]             v_q, v_d, en;
  logic [PIPE_DEPTH-1:0][IDX_W-1:0]  id_q, id_d;
  logic [PIPE_DEPTH-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [IDX_W-1:0]                  rr_q, rr_d, gnt_idx;
  logic [OCC_W-1:0]                  occ_q, occ_d;
  logic [IDX_W:0]                    cand;
  logic                              gnt_vld, accept, tail_full;

  // A stage loads unless it and every stage downstream of it are full while the output is held.
  always_comb begin
    en        = '0;
    tail_full = 1'b0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      tail_full = 1'b1;
      for (int j = k; j < PIPE_DEPTH; j++) begin
        tail_full = tail_full & v_q[j];
      end
      en[k] = ~tail_full | rsp_ready;
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = {1'b0, rr_q} + (IDX_W+1)'(off);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!gnt_vld && req_valid[cand[IDX_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[IDX_W-1:0];
      end
    end
  end

  assign accept = gnt_vld & en[0];

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign pipe_a = gnt_vld ? req_a[gnt_idx*OP_W +: OP_W] : '0;
  assign pipe_b = gnt_vld ? req_b[gnt_idx*OP_W +: OP_W] : '0;

  always_comb begin
    rr_d = rr_q;
    if (accept) begin
      rr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_comb begin
    v_d   = v_q;
    id_d  = id_q;
    tag_d = tag_q;
    if (en[0]) begin
      v_d[0]   = accept;
      id_d[0]  = accept ? gnt_idx : '0;
      tag_d[0] = accept ? req_tag[gnt_idx*TAG_W +: TAG_W] : '0;
    end
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      if (en[k]) begin
        v_d[k]   = v_q[k-1];
        id_d[k]  = id_q[k-1];
        tag_d[k] = tag_q[k-1];
      end
    end
  end

  always_comb begin
    occ_d = '0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      occ_d = occ_d + OCC_W'(v_d[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      id_q  <= '0;
      tag_q <= '0;
      rr_q  <= '0;
      occ_q <= '0;
    end else begin
      v_q   <= v_d;
      id_q  <= id_d;
      tag_q <= tag_d;
      rr_q  <= rr_d;
      occ_q <= occ_d;
    end
  end

  assign pipe_en   = en;
  assign rsp_valid = v_q[PIPE_DEPTH-1];
  assign rsp_id    = id_q[PIPE_DEPTH-1];
  assign rsp_tag   = tag_q[PIPE_DEPTH-1];
  assign occupancy = occ_q;

endmodule

`default_nettype wire
